axi_lite_init_sequencer: RTL and testbench
==========================================

Name: axi_lite_init_sequencer

Overview:
- AXI4-Lite write master that programs a register slave, such as the axi4_lite register block, from an external (address, data) table after a start pulse.
- Issues one write at a time, checks every B response, and aborts on the first non-OKAY response.
- Sits between the boot/config control logic and the slave's s_axi write channels.

Parameters:
ADDRESS_SIZE, 32, width of AW address and table address entries
DATA_SIZE, 32, width of W data and table data entries (multiple of 8)
INDEX_SIZE, 4, table index width; at most 2^INDEX_SIZE entries

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
start  in  1  one-cycle request to run the sequence; sampled only in IDLE
count  in  INDEX_SIZE+1  number of table entries to write; sampled with start
tbl_index  out  INDEX_SIZE  current table entry index
tbl_addr  in  ADDRESS_SIZE  address of entry tbl_index (combinational table)
tbl_data  in  DATA_SIZE  data of entry tbl_index
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at sequence end (success or abort)
error  out  1  sticky; set on a non-OKAY bresp, cleared by the next accepted start
error_index  out  INDEX_SIZE  index of the failing entry; valid while error=1
m_axi_awaddr  out  ADDRESS_SIZE  write address
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  DATA_SIZE  write data
m_axi_wstrb  out  DATA_SIZE/8  always all ones
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  2  write response (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR)
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready

Behaviour:
- All outputs are registered.
- Reset (async assert, sync deassert handled upstream) forces: state IDLE, tbl_index 0, busy 0, done 0, error 0, error_index 0, awaddr 0, wdata 0, awvalid 0, wvalid 0, bready 0.
- Reset mid-transaction drops all valids immediately; the slave is not waited on.
- FSM states: IDLE, FETCH, ISSUE, RESP.
- IDLE, start=1, count!=0: latch count, set tbl_index=0, clear error, set busy=1, go to FETCH.
- IDLE, start=1, count==0: clear error, pulse done next cycle, busy stays 0, no AXI activity.
- start while busy is ignored.
- FETCH (one cycle): register awaddr<=tbl_addr and wdata<=tbl_data; set awvalid=1 and wvalid=1; go to ISSUE.
- ISSUE: awvalid drops the cycle after awvalid&awready. wvalid drops the cycle after wvalid&wready. The two handshakes are independent and may complete in either order or the same cycle. awaddr and wdata stay stable while their valid is high. When both handshakes are complete, set bready=1 and go to RESP.
- RESP: on bvalid&bready, drop bready.
  - If bresp is 00 or 01 (success) and tbl_index==count-1: pulse done, clear busy, go to IDLE.
  - If success and more entries remain: tbl_index+1, go to FETCH.
  - If bresp is 10 or 11: set error=1, error_index=tbl_index, pulse done, clear busy, go to IDLE. Remaining entries are skipped.
- Minimum cost is 3 cycles per entry (FETCH, ISSUE, RESP) with ready/bvalid held high. done asserts the cycle after the final B handshake.
- count above 2^INDEX_SIZE is saturated to 2^INDEX_SIZE.
- tbl_index never wraps within a run.
- No timeout: a stalled slave holds the FSM in ISSUE or RESP indefinitely.

Test Plan:
1. count=1, entry0=(0x0,0xDEADBEEF), awready/wready/bvalid tied high, bresp=00, start at cycle 0 -> awvalid/wvalid high at cycle 2 with awaddr=0x0 and wdata=0xDEADBEEF, wstrb=0xF; done pulses at cycle 4; busy high cycles 1-3; error=0.
2. count=3, distinct entries, awready delayed 2 cycles, wready delayed 5 cycles -> each valid drops independently after its own handshake; exactly 3 writes in index order 0,1,2; bready asserted only after both handshakes; single done pulse.
3. count=4, bresp=10 on entry 1 -> only 2 writes issued; error=1, error_index=1, done pulses; next start with all-OKAY responses clears error.
4. start with count=0 -> done pulses next cycle, no awvalid, busy stays 0; start pulsed while busy -> ignored, write total unchanged.
5. Assert aresetn low while in ISSUE with awvalid=1 -> awvalid, wvalid, bready, busy go 0 immediately; after release a new start runs from index 0.
6. count=16 with INDEX_SIZE=4 and bresp=01 on all entries -> 16 writes, tbl_index reaches 15 without wrap, error=0.

Source files
------------

// File: rtl/axi_lite_init_sequencer_if.sv
// AXI4-Lite write-only channel bundle (AW, W, B) between the init sequencer and a register slave.
interface axi_lite_init_sequencer_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32
);
  logic [ADDRESS_SIZE-1:0]  awaddr;
  logic                     awvalid;
  logic                     awready;
  logic [DATA_SIZE-1:0]     wdata;
  logic [DATA_SIZE/8-1:0]   wstrb;
  logic                     wvalid;
  logic                     wready;
  logic [1:0]               bresp;
  logic                     bvalid;
  logic                     bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_init_sequencer.sv
// AXI4-Lite write master that replays an external (address, data) table into a register slave
// after a start pulse, one write at a time, aborting on the first SLVERR/DECERR response.
module axi_lite_init_sequencer #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int INDEX_SIZE   = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic [INDEX_SIZE:0]     count,
  output logic [INDEX_SIZE-1:0]   tbl_index,
  input  logic [ADDRESS_SIZE-1:0] tbl_addr,
  input  logic [DATA_SIZE-1:0]    tbl_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [INDEX_SIZE-1:0]   error_index,
  axi_lite_init_sequencer_if.master m_axi
);

  localparam int STRB_SIZE = DATA_SIZE / 8;
  localparam logic [INDEX_SIZE:0] ZERO_COUNT = {(INDEX_SIZE+1){1'b0}};
  localparam logic [INDEX_SIZE:0] ONE_COUNT  = {{INDEX_SIZE{1'b0}}, 1'b1};
  localparam logic [INDEX_SIZE:0] MAX_COUNT  = {1'b1, {INDEX_SIZE{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                    state_r;
  logic [INDEX_SIZE:0]       count_r;
  logic [INDEX_SIZE-1:0]     tbl_index_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      error_r;
  logic [INDEX_SIZE-1:0]     error_index_r;
  logic [ADDRESS_SIZE-1:0]   awaddr_r;
  logic [DATA_SIZE-1:0]      wdata_r;
  logic                      awvalid_r;
  logic                      wvalid_r;
  logic                      bready_r;

  logic [INDEX_SIZE:0]       sat_count_s;
  logic                      aw_complete_s;
  logic                      w_complete_s;
  logic                      b_handshake_s;
  logic                      b_success_s;
  logic                      last_entry_s;

  // Saturate the requested count and decode per-cycle handshake completion.
  always_comb begin
    sat_count_s   = count;
    aw_complete_s = 1'b0;
    w_complete_s  = 1'b0;
    if (count > MAX_COUNT) begin
      sat_count_s = MAX_COUNT;
    end else begin
      sat_count_s = count;
    end
    // A channel is finished once its valid has dropped or is being accepted this cycle.
    if (!awvalid_r || m_axi.awready) begin
      aw_complete_s = 1'b1;
    end else begin
      aw_complete_s = 1'b0;
    end
    if (!wvalid_r || m_axi.wready) begin
      w_complete_s = 1'b1;
    end else begin
      w_complete_s = 1'b0;
    end
  end

  assign b_handshake_s = m_axi.bvalid & bready_r;
  assign b_success_s   = (m_axi.bresp == 2'b00) || (m_axi.bresp == 2'b01);
  assign last_entry_s  = (({1'b0, tbl_index_r} + ONE_COUNT) == count_r);

  // Sequencer FSM with all outputs held in registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r       <= ST_IDLE;
      count_r       <= ZERO_COUNT;
      tbl_index_r   <= {INDEX_SIZE{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
      error_index_r <= {INDEX_SIZE{1'b0}};
      awaddr_r      <= {ADDRESS_SIZE{1'b0}};
      wdata_r       <= {DATA_SIZE{1'b0}};
      awvalid_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      bready_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            error_r <= 1'b0;
            if (count != ZERO_COUNT) begin
              count_r     <= sat_count_s;
              tbl_index_r <= {INDEX_SIZE{1'b0}};
              busy_r      <= 1'b1;
              state_r     <= ST_FETCH;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          awaddr_r  <= tbl_addr;
          wdata_r   <= tbl_data;
          awvalid_r <= 1'b1;
          wvalid_r  <= 1'b1;
          state_r   <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (awvalid_r && m_axi.awready) begin
            awvalid_r <= 1'b0;
          end
          if (wvalid_r && m_axi.wready) begin
            wvalid_r <= 1'b0;
          end
          if (aw_complete_s && w_complete_s) begin
            bready_r <= 1'b1;
            state_r  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (b_handshake_s) begin
            bready_r <= 1'b0;
            if (!b_success_s) begin
              error_r       <= 1'b1;
              error_index_r <= tbl_index_r;
              done_r        <= 1'b1;
              busy_r        <= 1'b0;
              state_r       <= ST_IDLE;
            end else if (last_entry_s) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              tbl_index_r <= tbl_index_r + {{(INDEX_SIZE-1){1'b0}}, 1'b1};
              state_r     <= ST_FETCH;
            end
          end
        end
        default: begin
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign tbl_index     = tbl_index_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
  assign error_index   = error_index_r;
  assign m_axi.awaddr  = awaddr_r;
  assign m_axi.awvalid = awvalid_r;
  assign m_axi.wdata   = wdata_r;
  assign m_axi.wstrb   = {STRB_SIZE{1'b1}};
  assign m_axi.wvalid  = wvalid_r;
  assign m_axi.bready  = bready_r;

endmodule

// File: tb/tb_axi_lite_init_sequencer.sv
// Scoreboard bench: a reference model predicts the write stream and done status per run,
// a slave model with programmable stalls answers, and a negedge monitor checks everything.
module tb_axi_lite_init_sequencer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int NE = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic [IW:0]   count = '0;
  logic [IW-1:0] tbl_index;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_data;
  logic          busy, done, error;
  logic [IW-1:0] error_index;

  axi_lite_init_sequencer_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) m_axi ();

  axi_lite_init_sequencer #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .INDEX_SIZE(IW)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .count(count),
    .tbl_index(tbl_index), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .busy(busy), .done(done), .error(error), .error_index(error_index),
    .m_axi(m_axi)
  );

  always #5 aclk = ~aclk;

  logic [AW-1:0] addr_mem [NE];
  logic [DW-1:0] data_mem [NE];
  assign tbl_addr = addr_mem[tbl_index];
  assign tbl_data = data_mem[tbl_index];

  int total = 0;
  int bad = 0;

  logic [AW-1:0] exp_aw_q [$];
  logic [DW-1:0] exp_w_q [$];
  logic [IW:0]   exp_done_q [$];
  logic [1:0]    resp_q [$];

  // slave model state: mode 0 = always ready, 1 = random stalls, 2 = fixed aw 2 / w 5 stall
  int mode = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0;
  bit aw_got = 0, w_got = 0;
  bit aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
  bit seen_aw = 0, seen_w = 0, bready_chk = 0;

  function automatic int pick_dly(input int which);
    if (mode == 0) return 0;
    if (mode == 2) return (which == 0) ? 2 : ((which == 1) ? 5 : 0);
    return $urandom_range(0, 4);
  endfunction

  task automatic set_mode(input int m);
    mode = m;
    aw_dly = pick_dly(0);
    w_dly  = pick_dly(1);
    b_dly  = pick_dly(2);
  endtask

  initial begin
    m_axi.awready = 1'b1;
    m_axi.wready  = 1'b1;
    m_axi.bvalid  = 1'b0;
    m_axi.bresp   = 2'b00;
  end

  // Slave model: reacts to handshakes seen at the previous negedge, drives just after the edge.
  always @(posedge aclk) begin
    #1;
    if (!aresetn) begin
      aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      m_axi.bvalid = 1'b0;
    end else begin
      if (b_hs_n) m_axi.bvalid = 1'b0;
      if (aw_hs_n) begin aw_got = 1; aw_cnt = 0; aw_dly = pick_dly(0); end
      else if (m_axi.awvalid) aw_cnt++;
      if (w_hs_n) begin w_got = 1; w_cnt = 0; w_dly = pick_dly(1); end
      else if (m_axi.wvalid) w_cnt++;
      if (aw_got && w_got && !m_axi.bvalid) begin
        if (b_cnt >= b_dly) begin
          m_axi.bvalid = 1'b1;
          m_axi.bresp  = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
          aw_got = 0; w_got = 0; b_cnt = 0; b_dly = pick_dly(2);
        end else begin
          b_cnt++;
        end
      end
    end
    m_axi.awready = (mode == 0) || (aw_cnt >= aw_dly);
    m_axi.wready  = (mode == 0) || (w_cnt >= w_dly);
  end

  // Monitor: checks every handshake and done pulse against the scoreboard queues.
  always @(negedge aclk) begin
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [IW:0]   es, as;
    aw_hs_n = aresetn && m_axi.awvalid && m_axi.awready;
    w_hs_n  = aresetn && m_axi.wvalid && m_axi.wready;
    b_hs_n  = aresetn && m_axi.bvalid && m_axi.bready;
    if (!aresetn) begin
      seen_aw = 0; seen_w = 0; bready_chk = 0;
    end else begin
      if (aw_hs_n) begin
        total++;
        if (exp_aw_q.size() == 0) begin
          bad++; $display("FAIL aw_unexpected: got addr=%h, required no write", m_axi.awaddr);
        end else begin
          ea = exp_aw_q.pop_front();
          if (m_axi.awaddr !== ea) begin
            bad++; $display("FAIL aw_addr: got %h required %h", m_axi.awaddr, ea);
          end
        end
        seen_aw = 1;
      end
      if (w_hs_n) begin
        total++;
        if (exp_w_q.size() == 0) begin
          bad++; $display("FAIL w_unexpected: got data=%h, required no write", m_axi.wdata);
        end else begin
          ed = exp_w_q.pop_front();
          if (m_axi.wdata !== ed || m_axi.wstrb !== 4'hF) begin
            bad++; $display("FAIL w_data: got %h/%h required %h/f", m_axi.wdata, m_axi.wstrb, ed);
          end
        end
        seen_w = 1;
      end
      if (m_axi.bready && !bready_chk) begin
        total++;
        bready_chk = 1;
        if (!(seen_aw && seen_w)) begin
          bad++; $display("FAIL bready_early: aw_done=%0d w_done=%0d required both 1", seen_aw, seen_w);
        end
      end
      if (b_hs_n) begin seen_aw = 0; seen_w = 0; bready_chk = 0; end
      if (done) begin
        total++;
        as = {error, error ? error_index : 4'd0};
        if (exp_done_q.size() == 0) begin
          bad++; $display("FAIL done_unexpected: got status=%h", as);
        end else begin
          es = exp_done_q.pop_front();
          if (as !== es) begin
            bad++; $display("FAIL done_status: got {error,idx}=%h required %h", as, es);
          end
        end
        total++;
        if (exp_aw_q.size() != 0 || exp_w_q.size() != 0 || busy !== 1'b0) begin
          bad++; $display("FAIL done_writes: pending aw=%0d w=%0d busy=%0d required 0 0 0",
                          exp_aw_q.size(), exp_w_q.size(), busy);
        end
      end
    end
  end

  task automatic fill_tables();
    for (int i = 0; i < NE; i++) begin
      addr_mem[i] = {$urandom_range(0, 1023), 2'b00};
      data_mem[i] = $urandom;
    end
  endtask

  // Reference model + driver for one run; resp_mode 0 OKAY, 1 EXOKAY, 2 random success code.
  task automatic run_seq(input int cnt, input int err_at, input int resp_mode,
                         input bit chk_timing, input bit poke_busy);
    int sat, nw, cyc, busy_cyc, done_cyc, aw_cyc;
    bit has_err;
    logic [1:0] r;
    sat = (cnt > NE) ? NE : cnt;
    has_err = (err_at >= 0) && (err_at < sat);
    nw = has_err ? err_at + 1 : sat;
    resp_q.delete();
    for (int i = 0; i < sat; i++) begin
      if (has_err && i == err_at) r = 2'($urandom_range(2, 3));
      else if (resp_mode == 2) r = 2'($urandom_range(0, 1));
      else r = 2'(resp_mode);
      resp_q.push_back(r);
    end
    for (int i = 0; i < nw; i++) begin
      exp_aw_q.push_back(addr_mem[i]);
      exp_w_q.push_back(data_mem[i]);
    end
    exp_done_q.push_back(has_err ? {1'b1, IW'(err_at)} : {(IW+1){1'b0}});
    @(posedge aclk); #1;
    start = 1'b1;
    count = (IW+1)'(cnt);
    @(negedge aclk);
    cyc = 0; busy_cyc = 0; done_cyc = -1; aw_cyc = -1;
    while (done_cyc < 0 && cyc < 3000) begin
      @(posedge aclk); #1;
      start = poke_busy && (cyc == 1);
      count = (IW+1)'(NE);
      @(negedge aclk);
      cyc++;
      if (busy) busy_cyc++;
      if (m_axi.awvalid && aw_cyc < 0) aw_cyc = cyc;
      if (done) done_cyc = cyc;
    end
    start = 1'b0;
    total++;
    if (done_cyc < 0) begin
      bad++; $display("FAIL run_timeout: no done within %0d cycles, count=%0d", cyc, cnt);
    end else if (chk_timing) begin
      if (done_cyc != 3 * nw + 1 || busy_cyc != 3 * nw || (nw > 0 && aw_cyc != 2) || (nw == 0 && aw_cyc != -1)) begin
        bad++; $display("FAIL run_timing: got done@%0d busy=%0d aw@%0d required done@%0d busy=%0d aw@%0d",
                        done_cyc, busy_cyc, aw_cyc, 3 * nw + 1, 3 * nw, (nw > 0) ? 2 : -1);
      end
    end
    @(negedge aclk);
    total++;
    if (done !== 1'b0 || error !== has_err) begin
      bad++; $display("FAIL after_done: got done=%0d error=%0d required 0 %0d", done, error, has_err);
    end
  endtask

  initial begin
    int c, e;
    fill_tables();
    set_mode(0);
    repeat (3) @(posedge aclk);
    #1;
    total++;
    if ({tbl_index, busy, done, error, error_index, m_axi.awaddr, m_axi.wdata,
         m_axi.awvalid, m_axi.wvalid, m_axi.bready} !== '0) begin
      bad++; $display("FAIL reset_state: got idx=%0d busy=%0d done=%0d err=%0d awv=%0d wv=%0d br=%0d required all 0",
                      tbl_index, busy, done, error, m_axi.awvalid, m_axi.wvalid, m_axi.bready);
    end
    @(negedge aclk); aresetn = 1'b1;

    addr_mem[0] = 32'h0000_0000;
    data_mem[0] = 32'hDEAD_BEEF;
    run_seq(1, -1, 0, 1'b1, 1'b0);

    fill_tables(); set_mode(2);
    run_seq(3, -1, 0, 1'b0, 1'b0);

    fill_tables(); set_mode(1);
    run_seq(4, 1, 0, 1'b0, 1'b0);
    run_seq(4, -1, 2, 1'b0, 1'b0);

    set_mode(0);
    run_seq(0, -1, 0, 1'b1, 1'b0);
    fill_tables();
    run_seq(5, -1, 2, 1'b1, 1'b1);

    set_mode(2);
    @(posedge aclk); #1; start = 1'b1; count = 5'd4;
    @(posedge aclk); #1; start = 1'b0;
    c = 0;
    while (!m_axi.awvalid && c < 20) begin @(negedge aclk); c++; end
    #2; aresetn = 1'b0; #1;
    total++;
    if (m_axi.awvalid !== 1'b0 || m_axi.wvalid !== 1'b0 || m_axi.bready !== 1'b0 || busy !== 1'b0 || c >= 20) begin
      bad++; $display("FAIL reset_mid: got awv=%0d wv=%0d br=%0d busy=%0d waited=%0d required 0 0 0 0 <20",
                      m_axi.awvalid, m_axi.wvalid, m_axi.bready, busy, c);
    end
    exp_aw_q.delete(); exp_w_q.delete(); exp_done_q.delete(); resp_q.delete();
    repeat (2) @(negedge aclk);
    #2; aresetn = 1'b1;
    set_mode(0); fill_tables();
    run_seq(3, -1, 2, 1'b1, 1'b0);

    fill_tables();
    run_seq(16, -1, 1, 1'b1, 1'b0);
    total++;
    if (tbl_index !== 4'd15) begin
      bad++; $display("FAIL full_table_index: got %0d required 15", tbl_index);
    end
    run_seq(25, -1, 0, 1'b1, 1'b0);

    for (int k = 0; k < 16; k++) begin
      set_mode(($urandom_range(0, 2) == 0) ? 0 : 1);
      fill_tables();
      c = $urandom_range(0, 31);
      e = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 17) : -1;
      run_seq(c, e, 2, (mode == 0), 1'b0);
    end

    repeat (3) @(negedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
